// File: rtl/mem_io_pkg.sv
// ---------------------------------------------------------------------------
// mem_io_pkg
// Shared definitions for the memory I/O controller:
//   - state_t            : access sequencer states
//   - WAIT_CYC_DEFAULT   : default per-region wait states (ROM=2, RAM=1)
//   - REGION_ROM/RAM     : region index constants
// ---------------------------------------------------------------------------
package mem_io_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    ERR    = 3'd4
  } state_t;

  // Packed 4-bit wait counts, slice [4r+3:4r] belongs to region r.
  localparam logic [7:0] WAIT_CYC_DEFAULT = {4'd1, 4'd2};

  localparam int REGION_ROM = 0;
  localparam int REGION_RAM = 1;

endpackage : mem_io_pkg

// File: rtl/mem_region_decode.sv
// ---------------------------------------------------------------------------
// mem_region_decode
// Combinational address decoder.
//   addr        in   CPU address
//   cs_onehot   out  one-hot chip-select vector (active high), 0 if unmapped
//   mapped      out  region index selects an existing chip select
//   local_addr  out  addr with the region bits cleared
//   wait_cnt    out  wait-state count of the selected region (0 if unmapped)
// ---------------------------------------------------------------------------
module mem_region_decode #(
  parameter int                  ADDR_W   = 16,
  parameter int                  REGION_W = 3,
  parameter int                  NUM_CS   = 2,
  parameter logic [4*NUM_CS-1:0] WAIT_CYC = mem_io_pkg::WAIT_CYC_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_CS-1:0] cs_onehot,
  output logic              mapped,
  output logic [ADDR_W-1:0] local_addr,
  output logic [3:0]        wait_cnt
);

  localparam logic [ADDR_W-1:0] LOCAL_MASK =
    {{REGION_W{1'b0}}, {(ADDR_W-REGION_W){1'b1}}};

  logic [REGION_W-1:0] region;

  assign region     = addr[ADDR_W-1 -: REGION_W];
  assign local_addr = addr & LOCAL_MASK;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign cs_onehot[gi] = (region == REGION_W'(gi));
    end
  endgenerate

  // A region is mapped exactly when it hits one of the chip selects.
  assign mapped = |cs_onehot;

  always_comb begin
    wait_cnt = '0;
    for (int r = 0; r < NUM_CS; r++) begin
      if (cs_onehot[r]) begin
        wait_cnt = WAIT_CYC[4*r +: 4];
      end
    end
  end

endmodule : mem_region_decode

// File: rtl/memory_io_ctrl.sv
// ---------------------------------------------------------------------------
// memory_io_ctrl
// Memory-bus controller between the pipeline memory stage and external
// ROM/RAM/peripherals. One access outstanding at a time; the memory stage
// sees req_ready low while an access is in flight.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_read/req_write/req_addr/
//   req_wdata                       request from memory stage
//   req_ready                       controller idle (accepts this cycle)
//   rsp_valid/rsp_rdata/rsp_error   one-cycle completion pulse
//   mem_addr/mem_wdata/mem_wdata_oe device-local address, write data/enable
//   mem_rdata                       read data from external bus
//   cs_n/oe_n/we_n                  active-low chip selects and strobes
//
// Sequence: IDLE -> SETUP (1) -> ACCESS (WAIT_CYC+1) -> HOLD (1) -> IDLE,
// or IDLE -> ERR (1) -> IDLE for illegal/unmapped requests.
// Every output is a register loaded from its *_next value, so the outputs
// visible in a state are computed on the transition into that state.
// ---------------------------------------------------------------------------
module memory_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int                  DATA_W   = 8,
  parameter int                  ADDR_W   = 16,
  parameter int                  REGION_W = 3,
  parameter int                  NUM_CS   = 2,
  parameter logic [4*NUM_CS-1:0] WAIT_CYC = WAIT_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [NUM_CS-1:0] cs_n,
  output logic              oe_n,
  output logic              we_n
);

  // -------------------------------------------------------------------------
  // Address decode of the incoming request
  // -------------------------------------------------------------------------
  logic [NUM_CS-1:0] dec_cs_onehot;
  logic              dec_mapped;
  logic [ADDR_W-1:0] dec_local_addr;
  logic [3:0]        dec_wait_cnt;

  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .REGION_W (REGION_W),
    .NUM_CS   (NUM_CS),
    .WAIT_CYC (WAIT_CYC)
  ) u_decode (
    .addr       (req_addr),
    .cs_onehot  (dec_cs_onehot),
    .mapped     (dec_mapped),
    .local_addr (dec_local_addr),
    .wait_cnt   (dec_wait_cnt)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [3:0]        wait_reg, wait_next;
  logic              is_write_reg, is_write_next;

  logic              req_ready_next;
  logic              rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_next;
  logic              rsp_error_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              mem_wdata_oe_next;
  logic [NUM_CS-1:0] cs_n_next;
  logic              oe_n_next;
  logic              we_n_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wait_reg     <= '0;
      is_write_reg <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      cs_n         <= '1;
      oe_n         <= 1'b1;
      we_n         <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wait_reg     <= wait_next;
      is_write_reg <= is_write_next;
      req_ready    <= req_ready_next;
      rsp_valid    <= rsp_valid_next;
      rsp_rdata    <= rsp_rdata_next;
      rsp_error    <= rsp_error_next;
      mem_addr     <= mem_addr_next;
      mem_wdata    <= mem_wdata_next;
      mem_wdata_oe <= mem_wdata_oe_next;
      cs_n         <= cs_n_next;
      oe_n         <= oe_n_next;
      we_n         <= we_n_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    wait_next         = wait_reg;
    is_write_next     = is_write_reg;
    rsp_valid_next    = 1'b0;
    rsp_rdata_next    = '0;
    rsp_error_next    = 1'b0;
    mem_addr_next     = mem_addr;
    mem_wdata_next    = mem_wdata;
    mem_wdata_oe_next = mem_wdata_oe;
    cs_n_next         = cs_n;
    oe_n_next         = 1'b1;
    we_n_next         = 1'b1;

    unique case (state_reg)
      IDLE: begin
        if (req_read && req_write) begin
          state_next     = ERR;
          rsp_valid_next = 1'b1;
          rsp_error_next = 1'b1;
        end else if (req_read || req_write) begin
          if (!dec_mapped) begin
            state_next     = ERR;
            rsp_valid_next = 1'b1;
            rsp_error_next = 1'b1;
          end else begin
            // Latch everything so the master may drop its request now.
            state_next        = SETUP;
            is_write_next     = req_write;
            wait_next         = dec_wait_cnt;
            mem_addr_next     = dec_local_addr;
            cs_n_next         = ~dec_cs_onehot;
            mem_wdata_oe_next = req_write;
            if (req_write) begin
              mem_wdata_next = req_wdata;
            end
          end
        end
      end

      SETUP: begin
        state_next = ACCESS;
        cnt_next   = wait_reg;
        oe_n_next  = is_write_reg;
        we_n_next  = ~is_write_reg;
      end

      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          // Last strobe cycle: capture read data and release strobes.
          state_next     = HOLD;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = is_write_reg ? '0 : mem_rdata;
        end else begin
          cnt_next  = cnt_reg - 4'd1;
          oe_n_next = is_write_reg;
          we_n_next = ~is_write_reg;
        end
      end

      HOLD: begin
        state_next        = IDLE;
        cs_n_next         = '1;
        mem_wdata_oe_next = 1'b0;
      end

      ERR: begin
        state_next = IDLE;
      end

      default: begin
        state_next        = IDLE;
        cs_n_next         = '1;
        mem_wdata_oe_next = 1'b0;
      end
    endcase

    req_ready_next = (state_next == IDLE);
  end

endmodule : memory_io_ctrl

// File: tb/tb_memory_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_memory_io_ctrl
// Directed self-checking bench for memory_io_ctrl with default parameters.
// Outputs are sampled on the falling edge; cycle k is the k-th falling edge
// after the rising edge that accepted the request.
// ctl = {cs_n[1:0], oe_n, we_n, mem_wdata_oe, rsp_valid, rsp_error, req_ready}
// ---------------------------------------------------------------------------
module tb_memory_io_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_read;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wdata_oe;
  logic [7:0]  mem_rdata;
  logic [1:0]  cs_n;
  logic        oe_n;
  logic        we_n;

  int checks;
  int failures;

  wire [7:0] ctl = {cs_n, oe_n, we_n, mem_wdata_oe, rsp_valid, rsp_error, req_ready};

  memory_io_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .mem_rdata    (mem_rdata),
    .cs_n         (cs_n),
    .oe_n         (oe_n),
    .we_n         (we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl[7:1] !== 7'b1111000) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected %b", ctl[7:1], 7'b1111000);
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected %h", {mem_addr, mem_wdata, rsp_rdata}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 8'b11110001) begin
      failures++;
      $display("FAIL reset_release_ctl: got %b expected %b", ctl, 8'b11110001);
    end
    $display("reset: ctl=%b", ctl);
  endtask

  // ------------------------------------------------------------------------
  task automatic test_idle();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ctl !== 8'b11110001) begin
        failures++;
        $display("FAIL idle_ctl: got %b expected %b", ctl, 8'b11110001);
      end
    end
    $display("idle: ctl=%b", ctl);
  endtask

  // ------------------------------------------------------------------------
  task automatic test_read_rom();
    logic [7:0] tab [6] = '{8'b10110000, 8'b10010000, 8'b10010000,
                            8'b10010000, 8'b10110100, 8'b11110001};
    req_read = 1'b1; req_addr = 16'h0123; mem_rdata = 8'h5A;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_read = 1'b0; req_addr = 16'hFFFF;
      end
      checks++;
      if (ctl !== tab[k-1]) begin
        failures++;
        $display("FAIL read_rom_ctl cycle %0d: got %b expected %b", k, ctl, tab[k-1]);
      end
      if (k <= 5) begin
        checks++;
        if (mem_addr !== 16'h0123) begin
          failures++;
          $display("FAIL read_rom_addr cycle %0d: got %h expected %h", k, mem_addr, 16'h0123);
        end
      end
      checks++;
      if (rsp_rdata !== ((k == 5) ? 8'hA5 : 8'h00)) begin
        failures++;
        $display("FAIL read_rom_rdata cycle %0d: got %h expected %h", k, rsp_rdata,
                 (k == 5) ? 8'hA5 : 8'h00);
      end
      // Only the last ACCESS cycle (k=4) presents the real data.
      mem_rdata = (k == 4) ? 8'hA5 : 8'h5A;
    end
    $display("read_rom: addr=0123 rdata=A5 done");
  endtask

  // ------------------------------------------------------------------------
  task automatic test_write_ram();
    logic [7:0] tab [5] = '{8'b01111000, 8'b01101000, 8'b01101000,
                            8'b01111100, 8'b11110001};
    req_write = 1'b1; req_addr = 16'h2040; req_wdata = 8'h3C;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_write = 1'b0; req_addr = 16'h0000; req_wdata = 8'hFF;
      end
      checks++;
      if (ctl !== tab[k-1]) begin
        failures++;
        $display("FAIL write_ram_ctl cycle %0d: got %b expected %b", k, ctl, tab[k-1]);
      end
      if (k <= 4) begin
        checks++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== {16'h0040, 8'h3C, 8'h00}) begin
          failures++;
          $display("FAIL write_ram_data cycle %0d: got %h expected %h", k,
                   {mem_addr, mem_wdata, rsp_rdata}, {16'h0040, 8'h3C, 8'h00});
        end
      end
    end
    $display("write_ram: addr=2040 wdata=3C done");
  endtask

  // ------------------------------------------------------------------------
  task automatic test_illegal();
    req_read = 1'b1; req_write = 1'b1; req_addr = 16'h0010;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    checks++;
    if (ctl !== 8'b11110110 || rsp_rdata !== 8'h00) begin
      failures++;
      $display("FAIL illegal_err: got ctl=%b rdata=%h expected ctl=%b rdata=00",
               ctl, rsp_rdata, 8'b11110110);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 8'b11110001) begin
      failures++;
      $display("FAIL illegal_return: got %b expected %b", ctl, 8'b11110001);
    end
    $display("illegal: rd+wr at 0010 done");
  endtask

  // ------------------------------------------------------------------------
  task automatic test_unmapped();
    logic [15:0] addrs [2] = '{16'hE000, 16'h4000};
    for (int i = 0; i < 2; i++) begin
      req_read = 1'b1; req_addr = addrs[i];
      @(negedge clk);
      req_read = 1'b0;
      checks++;
      if (ctl !== 8'b11110110) begin
        failures++;
        $display("FAIL unmapped_err addr %h: got %b expected %b", addrs[i], ctl, 8'b11110110);
      end
      @(negedge clk);
      checks++;
      if (ctl !== 8'b11110001) begin
        failures++;
        $display("FAIL unmapped_return addr %h: got %b expected %b", addrs[i], ctl, 8'b11110001);
      end
      $display("unmapped: read %h -> error", addrs[i]);
    end
  endtask

  // ------------------------------------------------------------------------
  task automatic test_back_to_back();
    int pulses;
    int first_k;
    int second_k;
    pulses = 0; first_k = -1; second_k = -1;
    req_read = 1'b1; req_addr = 16'h0100; mem_rdata = 8'h77;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
        else if (second_k < 0) second_k = k;
      end
      if (k == 11) req_read = 1'b0;
    end
    checks++;
    if (pulses !== 2 || first_k !== 5 || second_k !== 11) begin
      failures++;
      $display("FAIL back_to_back_pulses: got n=%0d at %0d,%0d expected n=2 at 5,11",
               pulses, first_k, second_k);
    end
    checks++;
    if (ctl !== 8'b11110001) begin
      failures++;
      $display("FAIL back_to_back_idle: got %b expected %b", ctl, 8'b11110001);
    end
    $display("back_to_back: pulses=%0d at %0d,%0d", pulses, first_k, second_k);
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset_mid_access();
    int got_k;
    req_write = 1'b1; req_addr = 16'h2040; req_wdata = 8'h3C;
    @(negedge clk);
    req_write = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== 8'b01101000) begin
      failures++;
      $display("FAIL reset_mid_strobe: got %b expected %b", ctl, 8'b01101000);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl[7:1] !== 7'b1111000) begin
      failures++;
      $display("FAIL reset_mid_abort: got %b expected %b", ctl[7:1], 7'b1111000);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || we_n !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_hold: got valid=%b we_n=%b expected valid=0 we_n=1",
                 rsp_valid, we_n);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 8'b11110001 || mem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_release: got ctl=%b addr=%h expected ctl=%b addr=0000",
               ctl, mem_addr, 8'b11110001);
    end
    req_read = 1'b1; req_addr = 16'h0005; mem_rdata = 8'hC3;
    got_k = -1;
    for (int k = 1; k <= 10 && got_k < 0; k++) begin
      @(negedge clk);
      req_read = 1'b0;
      if (rsp_valid === 1'b1) got_k = k;
    end
    checks++;
    if (got_k !== 5 || rsp_rdata !== 8'hC3 || rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_read: got cycle=%0d rdata=%h err=%b expected cycle=5 rdata=c3 err=0",
               got_k, rsp_rdata, rsp_error);
    end
    $display("reset_mid_access: recovery read at cycle %0d rdata=%h", got_k, rsp_rdata);
  endtask

  // ------------------------------------------------------------------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_idle();
    test_read_rom();
    test_write_ram();
    test_illegal();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_memory_io_ctrl
